// File: rtl/order_gateway.sv
// ============================================================================
// order_gateway
// ----------------------------------------------------------------------------
// Outbound order path between the strategy and the exchange-side link.
//
//   * Order requests are buffered in a DEPTH-entry FIFO.
//   * Every outbound transfer is gated on the registered safe_to_trade
//     verdict. A single unsafe cycle while running latches a kill-switch
//     HALT and flushes every queued order.
//   * While halted, every offered order is accepted and discarded so the
//     upstream never stalls. A rearm pulse coinciding with a safe verdict
//     returns the gateway to RUN.
//   * At most MAX_PER_WINDOW orders leave per WINDOW_CYCLES-cycle window.
//
// Optional build macro:
//   ORDER_GW_PRICE_CAP_EN - when defined, orders priced above MAX_PRICE
//                           (unsigned compare) are discarded at input.
//                           When undefined, MAX_PRICE is unused and no
//                           price check exists.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   safe_to_trade     firewall verdict (registered upstream)
//   rearm             single-cycle pulse requesting exit from HALT
//   in_valid/in_ready order request handshake
//   in_price/qty/side order request payload (side: 0=buy, 1=sell)
//   out_valid/ready   order-to-link handshake (out_valid may retract)
//   out_price/qty/side FIFO head payload
//   halted            1 while in HALT
//   reject_pulse      one-cycle pulse, the cycle after an input order
//                     is discarded
//   drop_count        saturating count of discarded and flushed orders
//   sent_count        wrapping count of orders transferred out
// ============================================================================
module order_gateway #(
    parameter int unsigned         DEPTH          = 8,
    parameter int unsigned         PRICE_W        = 32,
    parameter int unsigned         QTY_W          = 16,
    parameter int unsigned         MAX_PER_WINDOW = 4,
    parameter int unsigned         WINDOW_CYCLES  = 1000,
    parameter logic [PRICE_W-1:0]  MAX_PRICE      = PRICE_W'(1500000000)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               safe_to_trade,
    input  logic               rearm,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PRICE_W-1:0] in_price,
    input  logic [QTY_W-1:0]   in_qty,
    input  logic               in_side,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PRICE_W-1:0] out_price,
    output logic [QTY_W-1:0]   out_qty,
    output logic               out_side,
    output logic               halted,
    output logic               reject_pulse,
    output logic [15:0]        drop_count,
    output logic [15:0]        sent_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned WIN_W = $clog2(WINDOW_CYCLES);
    localparam int unsigned WS_W  = $clog2(MAX_PER_WINDOW + 1);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    typedef struct packed {
        logic               side;
        logic [QTY_W-1:0]   qty;
        logic [PRICE_W-1:0] price;
    } order_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e            state_q,    state_d;
    logic [PTR_W:0]    wr_ptr_q,   wr_ptr_d;
    logic [PTR_W:0]    rd_ptr_q,   rd_ptr_d;
    logic [15:0]       drop_q,     drop_d;
    logic [15:0]       sent_q,     sent_d;
    logic [WIN_W-1:0]  win_cnt_q,  win_cnt_d;
    logic [WS_W-1:0]   win_sent_q, win_sent_d;
    logic              reject_q,   reject_d;

    order_t            mem_q [DEPTH];

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]  occupancy;
    logic              fifo_empty;
    logic              fifo_full;
    logic              is_run;
    logic              rate_limited;
    logic              xfer;
    logic              accept;
    logic              price_over;
    logic              order_bad;
    logic              discard;
    logic              store;
    logic              flush;
    logic              win_wrap;
    logic [CNT_W:0]    drop_add;
    logic [31:0]       drop_sum;
    order_t            head;

    // Pointers carry one extra wrap bit so full and empty are distinct.
    assign occupancy    = wr_ptr_q - rd_ptr_q;
    assign fifo_empty   = (occupancy == '0);
    assign fifo_full    = (occupancy == CNT_W'(DEPTH));
    assign is_run       = (state_q == ST_RUN);
    assign rate_limited = (win_sent_q == WS_W'(MAX_PER_WINDOW));
    assign win_wrap     = (win_cnt_q == WIN_W'(WINDOW_CYCLES - 1));
    assign head         = mem_q[rd_ptr_q[PTR_W-1:0]];

`ifdef ORDER_GW_PRICE_CAP_EN
    assign price_over = (in_price > MAX_PRICE);
`else
    assign price_over = 1'b0;
`endif

    // The verdict gates out_valid combinationally: an unsafe cycle must
    // never see a transfer, even with a non-empty FIFO and a ready link.
    assign out_valid = !fifo_empty && is_run && safe_to_trade && !rate_limited;
    assign xfer      = out_valid && out_ready;

    // In HALT the upstream is never stalled; every offer is swallowed.
    // In RUN there is no full bypass, so a same-cycle pop does not help.
    assign in_ready  = is_run ? !fifo_full : 1'b1;
    assign accept    = in_valid && in_ready;
    assign order_bad = (in_qty == '0) || price_over;
    assign discard   = accept && (!is_run || order_bad);
    assign store     = accept && is_run && !order_bad;

    // The unsafe cycle itself empties the FIFO so HALT starts clean. An
    // order stored in that same cycle is flushed along with the rest.
    assign flush     = is_run && !safe_to_trade;

    assign out_price = head.price;
    assign out_qty   = head.qty;
    assign out_side  = head.side;

    assign halted       = (state_q == ST_HALT);
    assign reject_pulse = reject_q;
    assign drop_count   = drop_q;
    assign sent_count   = sent_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every signal written in always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        sent_d     = sent_q;
        win_cnt_d  = win_cnt_q;
        win_sent_d = win_sent_q;
        reject_d   = discard;
        drop_add   = '0;
        drop_sum   = '0;
        drop_d     = drop_q;

        // Kill switch and rearm
        if (is_run) begin
            if (!safe_to_trade) begin
                state_d = ST_HALT;
            end
        end else begin
            if (rearm && safe_to_trade) begin
                state_d = ST_RUN;
            end
        end

        // FIFO pointers
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (store) begin
                wr_ptr_d = wr_ptr_q + (PTR_W + 1)'(1);
            end
            if (xfer) begin
                rd_ptr_d = rd_ptr_q + (PTR_W + 1)'(1);
            end
        end

        // Drop accounting: flushed entries plus any discarded offer.
        if (flush) begin
            drop_add = {1'b0, occupancy} + (CNT_W + 1)'(store);
        end
        drop_add = drop_add + (CNT_W + 1)'(discard);
        drop_sum = 32'(drop_q) + 32'(drop_add);
        drop_d   = (drop_sum > 32'h0000_FFFF) ? 16'hFFFF : drop_sum[15:0];

        sent_d = sent_q + 16'(xfer);

        // Rate window: a transfer in the wrap cycle belongs to the new
        // window.
        if (win_wrap) begin
            win_cnt_d  = '0;
            win_sent_d = WS_W'(xfer);
        end else begin
            win_cnt_d  = win_cnt_q + WIN_W'(1);
            win_sent_d = win_sent_q + WS_W'(xfer);
        end
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            drop_q     <= '0;
            sent_q     <= '0;
            win_cnt_q  <= '0;
            win_sent_q <= '0;
            reject_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            drop_q     <= drop_d;
            sent_q     <= sent_d;
            win_cnt_q  <= win_cnt_d;
            win_sent_q <= win_sent_d;
            reject_q   <= reject_d;
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage
    // ------------------------------------------------------------------
    // NOTE: the storage array is not reset; the pointers alone define
    // which entries are valid, so resetting the data would only cost
    // routing and prevent a RAM mapping.
    always_ff @(posedge clk) begin
        if (store) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= '{side: in_side, qty: in_qty, price: in_price};
        end
    end

endmodule

// File: tb/tb_order_gateway.sv
// ============================================================================
// tb_order_gateway
// ----------------------------------------------------------------------------
// Self-checking bench for order_gateway. A queue-based reference model
// predicts every output each cycle; directed scenarios are followed by a
// long randomized run. Inputs change on the falling edge, outputs are
// sampled 1 time unit later, and the model advances across the rising edge.
// ============================================================================
module tb_order_gateway;

    localparam int          DEPTH     = 8;
    localparam int          PRICE_W   = 32;
    localparam int          QTY_W     = 16;
    localparam int          MPW       = 4;
    localparam int          WIN       = 20;
    localparam logic [31:0] MAX_PRICE = 32'd1500000000;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               safe_to_trade = 1'b1;
    logic               rearm = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [PRICE_W-1:0] in_price = '0;
    logic [QTY_W-1:0]   in_qty = '0;
    logic               in_side = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [PRICE_W-1:0] out_price;
    logic [QTY_W-1:0]   out_qty;
    logic               out_side;
    logic               halted;
    logic               reject_pulse;
    logic [15:0]        drop_count;
    logic [15:0]        sent_count;

    order_gateway #(
        .DEPTH          (DEPTH),
        .PRICE_W        (PRICE_W),
        .QTY_W          (QTY_W),
        .MAX_PER_WINDOW (MPW),
        .WINDOW_CYCLES  (WIN),
        .MAX_PRICE      (MAX_PRICE)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .safe_to_trade (safe_to_trade),
        .rearm         (rearm),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_price      (in_price),
        .in_qty        (in_qty),
        .in_side       (in_side),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_price     (out_price),
        .out_qty       (out_qty),
        .out_side      (out_side),
        .halted        (halted),
        .reject_pulse  (reject_pulse),
        .drop_count    (drop_count),
        .sent_count    (sent_count)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] price;
        logic [15:0] qty;
        logic        side;
    } ord_t;

    ord_t q[$];
    bit   m_halted;
    bit   m_rej;
    int   m_drop;
    int   m_sent;
    int   m_win_cnt;
    int   m_win_sent;

    int   n_checks = 0;
    int   n_pass   = 0;
    bit   last_xfer;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic void model_reset();
        q.delete();
        m_halted   = 1'b0;
        m_rej      = 1'b0;
        m_drop     = 0;
        m_sent     = 0;
        m_win_cnt  = 0;
        m_win_sent = 0;
    endfunction

    // Called at a falling edge: drive, check, advance model, wait for the
    // next falling edge (one rising edge in between).
    task automatic cyc(input bit v, input logic [31:0] price, input logic [15:0] qty,
                       input bit side, input bit ordy, input bit safe, input bit rearm_i);
        bit   exp_ready, exp_valid, xfer, acc, bad, discard, store;
        ord_t o;
        in_valid      = v;
        in_price      = price;
        in_qty        = qty;
        in_side       = side;
        out_ready     = ordy;
        safe_to_trade = safe;
        rearm         = rearm_i;
        #1;
        exp_ready = m_halted || (q.size() < DEPTH);
        exp_valid = !m_halted && safe && (q.size() != 0) && (m_win_sent < MPW);
        check("halted",       32'(halted),       32'(m_halted));
        check("reject_pulse", 32'(reject_pulse), 32'(m_rej));
        check("drop_count",   32'(drop_count),   32'(m_drop));
        check("sent_count",   32'(sent_count),   32'(m_sent));
        check("in_ready",     32'(in_ready),     32'(exp_ready));
        check("out_valid",    32'(out_valid),    32'(exp_valid));
        if (exp_valid) begin
            check("out_price", out_price,        q[0].price);
            check("out_qty",   32'(out_qty),     32'(q[0].qty));
            check("out_side",  32'(out_side),    32'(q[0].side));
        end
        last_xfer = out_valid && ordy;

        xfer = exp_valid && ordy;
        acc  = v && exp_ready;
        bad  = (qty == 16'd0);
`ifdef ORDER_GW_PRICE_CAP_EN
        bad  = bad || (price > MAX_PRICE);
`endif
        discard = acc && (m_halted || bad);
        store   = acc && !m_halted && !bad;

        if (!m_halted && !safe) begin
            m_drop  += q.size() + int'(store) + int'(discard);
            q.delete();
            m_halted = 1'b1;
        end else begin
            if (xfer) void'(q.pop_front());
            if (store) begin
                o.price = price;
                o.qty   = qty;
                o.side  = side;
                q.push_back(o);
            end
            m_drop += int'(discard);
            if (m_halted && rearm_i && safe) m_halted = 1'b0;
        end
        if (m_drop > 65535) m_drop = 65535;
        m_sent = (m_sent + int'(xfer)) % 65536;
        m_rej  = discard;
        if (m_win_cnt == WIN - 1) begin
            m_win_cnt  = 0;
            m_win_sent = int'(xfer);
        end else begin
            m_win_cnt++;
            m_win_sent += int'(xfer);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 32'd0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    // Called at a falling edge; reset is asserted asynchronously and the
    // outputs are checked while it is held.
    task automatic do_reset();
        rst_n         = 1'b0;
        in_valid      = 1'b0;
        out_ready     = 1'b0;
        safe_to_trade = 1'b1;
        rearm         = 1'b0;
        #1;
        check("rst_out_valid",    32'(out_valid),    32'd0);
        check("rst_halted",       32'(halted),       32'd0);
        check("rst_reject_pulse", 32'(reject_pulse), 32'd0);
        check("rst_drop_count",   32'(drop_count),   32'd0);
        check("rst_sent_count",   32'(sent_count),   32'd0);
        check("rst_in_ready",     32'(in_ready),     32'd1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int cnt_a, cnt_b;
        bit s, ra, v, ordy;
        logic [31:0] pr;
        logic [15:0] qt;

        @(negedge clk);
        do_reset();

        // Three orders in sequence, link always ready.
        cyc(1'b1, 32'd100, 16'd5, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 32'd200, 16'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 32'd300, 16'd5, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(3);
        check("t1_sent", 32'(sent_count), 32'd3);
        check("t1_drop", 32'(drop_count), 32'd0);

        // Fill to full with the link stalled, then pop+push together.
        do_reset();
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 32'(i + 1), 16'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t2_full_in_ready", 32'(in_ready), 32'd0);
        cyc(1'b1, 32'd99, 16'd1, 1'b0, 1'b1, 1'b1, 1'b0);
        check("t2_after_pop_in_ready", 32'(in_ready), 32'd1);

        // Kill switch: five queued, one unsafe cycle.
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1'b1, 32'(10 + i), 16'd2, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 32'd0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("t3_halted", 32'(halted),     32'd1);
        check("t3_drop5",  32'(drop_count), 32'd5);
        cyc(1'b1, 32'd7, 16'd3, 1'b0, 1'b1, 1'b1, 1'b0);
        check("t3_rej1",   32'(reject_pulse), 32'd1);
        cyc(1'b1, 32'd8, 16'd3, 1'b0, 1'b1, 1'b1, 1'b0);
        check("t3_drop7",  32'(drop_count), 32'd7);
        cyc(1'b0, 32'd0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("t3_rearm_unsafe", 32'(halted), 32'd1);
        cyc(1'b0, 32'd0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        check("t3_rearm_safe",   32'(halted), 32'd0);

        // Rate limit: continuous supply, count transfers per window.
        do_reset();
        cnt_a = 0;
        cnt_b = 0;
        for (int k = 0; k < 2 * WIN; k++) begin
            cyc(1'b1, 32'($urandom_range(1, 1000000)), 16'($urandom_range(1, 65535)),
                1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b0);
            if (k < WIN) cnt_a += int'(last_xfer);
            else         cnt_b += int'(last_xfer);
        end
        check("t4_window0_sent", 32'(cnt_a), 32'(MPW));
        check("t4_window1_sent", 32'(cnt_b), 32'(MPW));

        // Zero quantity is swallowed without touching the FIFO.
        do_reset();
        cyc(1'b1, 32'd50, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t5_qty0_rej",   32'(reject_pulse), 32'd1);
        check("t5_qty0_empty", 32'(out_valid),    32'd0);
`ifdef ORDER_GW_PRICE_CAP_EN
        cyc(1'b1, 32'd1500000001, 16'd7, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t5_cap_over_rej", 32'(reject_pulse), 32'd1);
        cyc(1'b1, 32'd1500000000, 16'd7, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t5_cap_eq_rej",   32'(reject_pulse), 32'd0);
        check("t5_cap_eq_valid", 32'(out_valid),    32'd1);
        check("t5_cap_eq_price", out_price,         32'd1500000000);
`endif

        // Reset in the middle of traffic.
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'(500 + i), 16'd9, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t6_pre_valid", 32'(out_valid), 32'd1);
        do_reset();
        idle(2);

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            v    = ($urandom_range(0, 99) < 60);
            ordy = ($urandom_range(0, 99) < 70);
            s    = ($urandom_range(0, 99) < 97);
            ra   = ($urandom_range(0, 99) < 15);
            qt   = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
            if ($urandom_range(0, 1) == 1) pr = MAX_PRICE - 32'd2 + 32'($urandom_range(0, 4));
            else                           pr = $urandom;
            cyc(v, pr, qt, 1'($urandom_range(0, 1)), ordy, s, ra);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/order_gateway.md
Name: order_gateway

Overview:
- Outbound order path that consumes the registered safe_to_trade verdict and emits orders to the exchange-side link.
- Buffers order requests in a small FIFO and gates every transfer on the safe verdict.
- Latches a kill-switch HALT on any unsafe cycle and flushes queued orders.
- Enforces a per-window order rate limit.

Parameters:
DEPTH, 8, FIFO entries (power of 2, >=2)
PRICE_W, 32, price field width
QTY_W, 16, quantity field width
MAX_PER_WINDOW, 4, max orders sent per rate window (>=1)
WINDOW_CYCLES, 1000, rate window length in clk cycles (>=2)
MAX_PRICE, 1500000000, price ceiling, used only with the optional feature

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
safe_to_trade  in  1  firewall verdict, registered upstream
rearm  in  1  single-cycle pulse requesting exit from HALT
in_valid  in  1  order request valid
in_ready  out  1  order request accepted when in_valid&in_ready
in_price  in  PRICE_W  order price
in_qty  in  QTY_W  order quantity
in_side  in  1  0=buy 1=sell
out_valid  out  1  order to link valid
out_ready  in  1  link accepts when out_valid&out_ready
out_price  out  PRICE_W  head order price
out_qty  out  QTY_W  head order quantity
out_side  out  1  head order side
halted  out  1  1 while in HALT
reject_pulse  out  1  one-cycle pulse per discarded input order
drop_count  out  16  saturating count of discarded/flushed orders
sent_count  out  16  wrapping count of orders transferred out

Behaviour:
- Reset (async assert, sync release): state=RUN, FIFO empty, halted=0, reject_pulse=0, drop_count=0, sent_count=0, window counter=0, window sent=0.
- State RUN:
  - Any cycle with safe_to_trade=0 -> HALT next cycle.
  - In that same cycle, out_valid is forced 0, so no transfer occurs on an unsafe cycle.
- State HALT:
  - halted=1.
  - On entry, FIFO is flushed in one cycle; drop_count += occupancy (saturating at 16'hFFFF).
  - in_ready=1 (upstream never stalls). Each offered order is discarded: reject_pulse=1, drop_count+1.
  - out_valid=0.
  - rearm=1 with safe_to_trade=1 in the same cycle -> RUN next cycle. rearm with safe_to_trade=0 is ignored.
- out_valid = FIFO non-empty & state==RUN & safe_to_trade & !rate_limited.
  - out_valid is combinationally gated, so it may retract without a transfer. The downstream link is required to tolerate this.
  - Payload reflects the FIFO head and is stable while out_valid=1.
- Input in RUN:
  - in_ready = !full.
  - in_qty==0 -> order accepted but not stored; reject_pulse=1, drop_count+1.
  - No full bypass: a pop in the same cycle does not raise in_ready when full.
- Latency: an order accepted in cycle N is first visible on out_valid in cycle N+1 (registered FIFO). Push and pop in the same cycle are both legal when not full and not empty.
- Rate limit:
  - Window counter counts 0..WINDOW_CYCLES-1, then wraps.
  - At wrap, window sent resets to 0. If a transfer occurs in the wrap cycle, window sent is set to 1.
  - rate_limited = (window sent == MAX_PER_WINDOW).
  - The window counter runs in all states.
- sent_count increments on each out transfer and wraps at 16 bits.
- Simultaneous events: safe_to_trade=0 in the same cycle as a pending transfer -> no transfer, HALT, flush includes the head entry.
- Reset mid-operation: all state is cleared immediately and queued orders are lost. Lost orders are not counted in drop_count.

Optional Feature:
- Macro ORDER_GW_PRICE_CAP_EN.
- When defined: an input order with in_price > MAX_PRICE (unsigned) is discarded at input in RUN. in_ready follows normal rules; reject_pulse=1 and drop_count+1.
- When undefined: no price check, MAX_PRICE is unused, and the logic is absent.

Test Plan:
- Reset, push 3 orders (price 100/200/300, qty 5), out_ready=1, safe=1 -> out transfers in order starting the cycle after the first accept; sent_count=3; drop_count=0.
- Fill 8 entries with out_ready=0 -> in_ready=0 at occupancy 8. Pop one and push in the same cycle -> in_ready stays 0 that cycle.
- Queue 5, drop safe_to_trade for 1 cycle -> no transfer that cycle; halted=1 next cycle; drop_count=5.
  - Offering 2 more orders -> 2 reject_pulses, drop_count=7.
  - rearm with safe=0 -> still halted; rearm with safe=1 -> RUN.
- MAX_PER_WINDOW=4, WINDOW_CYCLES=20, 10 queued, out_ready=1 -> 4 sent, out_valid=0 until the wrap at cycle 20, then the next 4 are sent.
- Push in_qty=0 -> reject_pulse=1, FIFO unchanged. With ORDER_GW_PRICE_CAP_EN, push price 1500000001 -> rejected; push price 1500000000 -> accepted.
- Assert rst_n low with 4 queued and out_valid high -> out_valid=0 immediately; all counters are 0 after release.
